// File: rtl/gx_reset_seq.sv
// Transceiver reset sequencer for one GX link: orders TX/RX analog and digital resets across CH_N lanes.
// Optional RX lock watchdog with retry pulse is built when GX_RESET_LTD_WATCHDOG_EN is defined.
module gx_reset_seq #(
    parameter int unsigned CH_N       = 1,
    parameter int unsigned T_ARST_CYC = 5,
    parameter int unsigned T_DRST_CYC = 5,
    parameter int unsigned T_LTD_CYC  = 200
`ifdef GX_RESET_LTD_WATCHDOG_EN
    ,
    parameter int unsigned T_WD_CYC   = 1 << 20
`endif
) (
    input  logic            OSC_50m,
    input  logic            FPGA_RSTn,
    input  logic            pll_locked_i,
    input  logic [CH_N-1:0] tx_cal_busy_i,
    input  logic [CH_N-1:0] rx_cal_busy_i,
    input  logic [CH_N-1:0] rx_is_lockedtodata_i,
    output logic [CH_N-1:0] gx_tx_analogreset_o,
    output logic [CH_N-1:0] gx_tx_digitalreset_o,
    output logic [CH_N-1:0] gx_rx_analogreset_o,
    output logic [CH_N-1:0] gx_rx_digitalreset_o,
    output logic            tx_ready_o,
    output logic            rx_ready_o
`ifdef GX_RESET_LTD_WATCHDOG_EN
    ,
    output logic            rx_wd_retry_o
`endif
);

    localparam int unsigned TxCntMax = (T_ARST_CYC > T_DRST_CYC) ? T_ARST_CYC : T_DRST_CYC;
    localparam int unsigned RxCntMax = (T_ARST_CYC > T_LTD_CYC) ? T_ARST_CYC : T_LTD_CYC;
    localparam int unsigned TxCntW   = $clog2(TxCntMax + 1);
    localparam int unsigned RxCntW   = $clog2(RxCntMax + 1);
    localparam int unsigned InW      = 1 + 3 * CH_N;

    localparam logic [TxCntW-1:0] TxArstLast = TxCntW'(T_ARST_CYC - 1);
    localparam logic [TxCntW-1:0] TxDrstLast = TxCntW'(T_DRST_CYC - 1);
    localparam logic [RxCntW-1:0] RxArstLast = RxCntW'(T_ARST_CYC - 1);
    localparam logic [RxCntW-1:0] RxLtdLast  = RxCntW'(T_LTD_CYC - 1);

    // Reset release synchroniser; FSMs only advance once run is high
    logic [1:0] rst_sync_q;
    logic       run;

    always_ff @(posedge OSC_50m or negedge FPGA_RSTn) begin
        if (!FPGA_RSTn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    logic [InW-1:0] async_in;
    logic [InW-1:0] meta_q;
    logic [InW-1:0] sync_q;

    assign async_in = {pll_locked_i, tx_cal_busy_i, rx_cal_busy_i, rx_is_lockedtodata_i};

    always_ff @(posedge OSC_50m or negedge FPGA_RSTn) begin
        if (!FPGA_RSTn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    logic pll_s;
    logic tx_busy_s;
    logic rx_busy_s;
    logic rx_lock_s;
    logic tx_ok;

    assign pll_s     = sync_q[InW-1];
    assign tx_busy_s = |sync_q[3*CH_N-1 -: CH_N];
    assign rx_busy_s = |sync_q[2*CH_N-1 -: CH_N];
    assign rx_lock_s = &sync_q[CH_N-1:0];
    assign tx_ok     = ~tx_busy_s & pll_s;

    // ---------------------------------------------------------------- TX
    typedef enum logic [1:0] {TArst, TCal, TDrst, TReady} tx_state_e;

    tx_state_e          tx_state_q, tx_state_d;
    logic [TxCntW-1:0]  tx_cnt_q, tx_cnt_d;
    logic               tx_an_q, tx_an_d;
    logic               tx_dig_q, tx_dig_d;
    logic               tx_rdy_q, tx_rdy_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        if (run) begin
            unique case (tx_state_q)
                TArst: begin
                    if (tx_cnt_q >= TxArstLast) begin
                        tx_state_d = TCal;
                        tx_cnt_d   = '0;
                    end else begin
                        tx_cnt_d = tx_cnt_q + TxCntW'(1);
                    end
                end
                TCal: begin
                    // The cycle that satisfies the condition is the first of the hold window
                    if (tx_ok) begin
                        if (T_DRST_CYC <= 1) begin
                            tx_state_d = TReady;
                            tx_cnt_d   = '0;
                        end else begin
                            tx_state_d = TDrst;
                            tx_cnt_d   = TxCntW'(1);
                        end
                    end
                end
                TDrst: begin
                    if (tx_busy_s) begin
                        tx_state_d = TCal;
                        tx_cnt_d   = '0;
                    end else if (!pll_s) begin
                        tx_cnt_d = '0;
                    end else if (tx_cnt_q >= TxDrstLast) begin
                        tx_state_d = TReady;
                        tx_cnt_d   = '0;
                    end else begin
                        tx_cnt_d = tx_cnt_q + TxCntW'(1);
                    end
                end
                TReady: begin
                    if (tx_busy_s) begin
                        tx_state_d = TCal;
                        tx_cnt_d   = '0;
                    end else if (!pll_s) begin
                        tx_state_d = TDrst;
                        tx_cnt_d   = '0;
                    end
                end
                default: begin
                    tx_state_d = TArst;
                    tx_cnt_d   = '0;
                end
            endcase
        end
        tx_an_d  = (tx_state_d == TArst);
        tx_dig_d = (tx_state_d != TReady);
        tx_rdy_d = (tx_state_d == TReady);
    end

    always_ff @(posedge OSC_50m or negedge FPGA_RSTn) begin
        if (!FPGA_RSTn) begin
            tx_state_q <= TArst;
            tx_cnt_q   <= '0;
            tx_an_q    <= 1'b1;
            tx_dig_q   <= 1'b1;
            tx_rdy_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_an_q    <= tx_an_d;
            tx_dig_q   <= tx_dig_d;
            tx_rdy_q   <= tx_rdy_d;
        end
    end

    // ---------------------------------------------------------------- RX
    typedef enum logic [1:0] {RArst, RCal, RLtd, RReady} rx_state_e;

    rx_state_e          rx_state_q, rx_state_d;
    logic [RxCntW-1:0]  rx_cnt_q, rx_cnt_d;
    logic               rx_an_q, rx_an_d;
    logic               rx_dig_q, rx_dig_d;
    logic               rx_rdy_q, rx_rdy_d;

`ifdef GX_RESET_LTD_WATCHDOG_EN
    localparam int unsigned     WdW    = $clog2(T_WD_CYC + 1);
    localparam logic [WdW-1:0]  WdLast = WdW'(T_WD_CYC - 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           wd_fire;
    logic           retry_q;
`endif

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
`ifdef GX_RESET_LTD_WATCHDOG_EN
        wd_fire    = 1'b0;
`endif
        if (run) begin
            unique case (rx_state_q)
                RArst: begin
                    if (rx_cnt_q >= RxArstLast) begin
                        rx_state_d = RCal;
                        rx_cnt_d   = '0;
                    end else begin
                        rx_cnt_d = rx_cnt_q + RxCntW'(1);
                    end
                end
                RCal: begin
                    if (!rx_busy_s) begin
                        if (rx_lock_s && (T_LTD_CYC <= 1)) begin
                            rx_state_d = RReady;
                            rx_cnt_d   = '0;
                        end else begin
                            rx_state_d = RLtd;
                            rx_cnt_d   = rx_lock_s ? RxCntW'(1) : '0;
                        end
                    end
                end
                RLtd: begin
                    if (rx_busy_s) begin
                        rx_state_d = RCal;
                        rx_cnt_d   = '0;
                    end else if (!rx_lock_s) begin
                        rx_cnt_d = '0;
                    end else if (rx_cnt_q >= RxLtdLast) begin
                        rx_state_d = RReady;
                        rx_cnt_d   = '0;
                    end else begin
                        rx_cnt_d = rx_cnt_q + RxCntW'(1);
                    end
                end
                RReady: begin
                    if (rx_busy_s) begin
                        rx_state_d = RCal;
                        rx_cnt_d   = '0;
                    end else if (!rx_lock_s) begin
                        rx_state_d = RLtd;
                        rx_cnt_d   = '0;
                    end
                end
                default: begin
                    rx_state_d = RArst;
                    rx_cnt_d   = '0;
                end
            endcase
`ifdef GX_RESET_LTD_WATCHDOG_EN
            // Lock window never completed: retry with a full analog reset
            if ((rx_state_q == RLtd) && (rx_state_d == RLtd) && (wd_q >= WdLast)) begin
                rx_state_d = RArst;
                rx_cnt_d   = '0;
                wd_fire    = 1'b1;
            end
`endif
        end
`ifdef GX_RESET_LTD_WATCHDOG_EN
        wd_d = ((rx_state_q == RLtd) && (rx_state_d == RLtd)) ? wd_q + WdW'(1) : '0;
`endif
        rx_an_d  = (rx_state_d == RArst);
        rx_dig_d = (rx_state_d != RReady);
        rx_rdy_d = (rx_state_d == RReady);
    end

    always_ff @(posedge OSC_50m or negedge FPGA_RSTn) begin
        if (!FPGA_RSTn) begin
            rx_state_q <= RArst;
            rx_cnt_q   <= '0;
            rx_an_q    <= 1'b1;
            rx_dig_q   <= 1'b1;
            rx_rdy_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_an_q    <= rx_an_d;
            rx_dig_q   <= rx_dig_d;
            rx_rdy_q   <= rx_rdy_d;
        end
    end

`ifdef GX_RESET_LTD_WATCHDOG_EN
    always_ff @(posedge OSC_50m or negedge FPGA_RSTn) begin
        if (!FPGA_RSTn) begin
            wd_q    <= '0;
            retry_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            retry_q <= wd_fire;
        end
    end

    assign rx_wd_retry_o = retry_q;
`endif

    assign gx_tx_analogreset_o  = {CH_N{tx_an_q}};
    assign gx_tx_digitalreset_o = {CH_N{tx_dig_q}};
    assign gx_rx_analogreset_o  = {CH_N{rx_an_q}};
    assign gx_rx_digitalreset_o = {CH_N{rx_dig_q}};
    assign tx_ready_o           = tx_rdy_q;
    assign rx_ready_o           = rx_rdy_q;

endmodule

// File: tb/tb_gx_reset_seq.sv
// Self-checking bench for gx_reset_seq (4 lanes); reference model tracks run lengths of the
// synchronised release conditions. Define GX_RESET_LTD_WATCHDOG_EN to also test the watchdog.
`timescale 1ns/1ps
module tb_gx_reset_seq;
    localparam int CH_N   = 4;
    localparam int T_ARST = 5;
    localparam int T_DRST = 5;
    localparam int T_LTD  = 200;
`ifdef GX_RESET_LTD_WATCHDOG_EN
    localparam int T_WD   = 1000;
`endif
    localparam int OW = 4 * CH_N + 2;
    localparam logic [OW-1:0] RESET_VEC = {{(4 * CH_N){1'b1}}, 2'b00};

    logic            OSC_50m = 1'b0;
    logic            FPGA_RSTn;
    logic            pll_locked;
    logic [CH_N-1:0] tx_cal_busy, rx_cal_busy, rx_ltd;
    logic [CH_N-1:0] tx_an, tx_dig, rx_an, rx_dig;
    logic            tx_ready, rx_ready;
`ifdef GX_RESET_LTD_WATCHDOG_EN
    logic            rx_wd_retry;
`endif
    logic [OW-1:0]   obs;

    int checks = 0;
    int errors = 0;

    // Reference model: edges since release, analog cycles served, consecutive-good run lengths
    int edges, arst_done, tx_run, rx_run;
    logic [3*CH_N:0] h1, h2;

    always #10 OSC_50m = ~OSC_50m;

    assign obs = {tx_an, tx_dig, rx_an, rx_dig, tx_ready, rx_ready};

    gx_reset_seq #(
        .CH_N       (CH_N),
        .T_ARST_CYC (T_ARST),
        .T_DRST_CYC (T_DRST),
        .T_LTD_CYC  (T_LTD)
`ifdef GX_RESET_LTD_WATCHDOG_EN
        ,
        .T_WD_CYC   (T_WD)
`endif
    ) dut (
        .OSC_50m              (OSC_50m),
        .FPGA_RSTn            (FPGA_RSTn),
        .pll_locked_i         (pll_locked),
        .tx_cal_busy_i        (tx_cal_busy),
        .rx_cal_busy_i        (rx_cal_busy),
        .rx_is_lockedtodata_i (rx_ltd),
        .gx_tx_analogreset_o  (tx_an),
        .gx_tx_digitalreset_o (tx_dig),
        .gx_rx_analogreset_o  (rx_an),
        .gx_rx_digitalreset_o (rx_dig),
        .tx_ready_o           (tx_ready),
        .rx_ready_o           (rx_ready)
`ifdef GX_RESET_LTD_WATCHDOG_EN
        ,
        .rx_wd_retry_o        (rx_wd_retry)
`endif
    );

    function automatic logic [OW-1:0] model_out();
        logic ana, txr, rxr;
        ana = (arst_done < T_ARST);
        txr = !ana && (tx_run >= T_DRST);
        rxr = !ana && (rx_run >= T_LTD);
        return {{CH_N{ana}}, {CH_N{!txr}}, {CH_N{ana}}, {CH_N{!rxr}}, txr, rxr};
    endfunction

    task automatic model_reset();
        edges = 0; arst_done = 0; tx_run = 0; rx_run = 0; h1 = '0; h2 = '0;
    endtask

    task automatic model_edge();
        logic p, tb, rb, lk;
        p  = h2[3*CH_N];
        tb = |h2[3*CH_N-1 -: CH_N];
        rb = |h2[2*CH_N-1 -: CH_N];
        lk = &h2[CH_N-1:0];
        // Two edges after release for the reset synchroniser, then analog hold, then evaluation
        if (edges >= 2) begin
            if (arst_done < T_ARST) begin
                arst_done++;
            end else begin
                tx_run = (!tb && p) ? ((tx_run < T_LTD) ? tx_run + 1 : tx_run) : 0;
                rx_run = (!rb && lk) ? ((rx_run < T_LTD) ? rx_run + 1 : rx_run) : 0;
            end
        end
        edges++;
        h2 = h1;
        h1 = {pll_locked, tx_cal_busy, rx_cal_busy, rx_ltd};
    endtask

    task automatic step();
        @(posedge OSC_50m);
        model_edge();
        @(negedge OSC_50m);
    endtask

    task automatic set_good();
        pll_locked = 1'b1; tx_cal_busy = '0; rx_cal_busy = '0; rx_ltd = '1;
    endtask

    task automatic apply_reset();
        FPGA_RSTn = 1'b0;
        model_reset();
        repeat (3) @(negedge OSC_50m);
        FPGA_RSTn = 1'b1;
    endtask

    task automatic test_reset();
        set_good();
        FPGA_RSTn = 1'b0;
        model_reset();
        repeat (2) @(negedge OSC_50m);
        checks++;
        if (obs !== RESET_VEC) begin
            errors++; $display("FAIL reset_hold: got %h expected %h", obs, RESET_VEC);
        end
        FPGA_RSTn = 1'b1;
        for (int n = 1; n <= 2; n++) begin
            step();
            checks++;
            if (obs !== RESET_VEC) begin
                errors++; $display("FAIL reset_sync cycle %0d: got %h expected %h", n, obs, RESET_VEC);
            end
        end
    endtask

    task automatic test_power_up();
        int t_an = -1, t_tx = -1, t_rx = -1;
        set_good();
        apply_reset();
        for (int n = 1; n <= 260; n++) begin
            step();
            checks++;
            if (obs !== model_out()) begin
                errors++; $display("FAIL power_up cycle %0d: got %h expected %h", n, obs, model_out());
            end
            if (t_an < 0 && tx_an == '0) t_an = n;
            if (t_tx < 0 && tx_ready) t_tx = n;
            if (t_rx < 0 && rx_ready) t_rx = n;
        end
        checks++;
        if (t_an != 2 + T_ARST) begin
            errors++; $display("FAIL power_up_analog_edge: got %0d expected %0d", t_an, 2 + T_ARST);
        end
        checks++;
        if (t_tx != 2 + T_ARST + T_DRST) begin
            errors++; $display("FAIL power_up_tx_ready_edge: got %0d expected %0d", t_tx, 2 + T_ARST + T_DRST);
        end
        checks++;
        if (t_rx != 2 + T_ARST + T_LTD) begin
            errors++; $display("FAIL power_up_rx_ready_edge: got %0d expected %0d", t_rx, 2 + T_ARST + T_LTD);
        end
    endtask

    task automatic test_cal_hold();
        int t_rel = -1;
        set_good();
        tx_cal_busy = CH_N'($urandom_range(1, (1 << CH_N) - 1));
        apply_reset();
        for (int n = 1; n <= 2 + T_ARST + 1000; n++) begin
            step();
            checks++;
            if (obs !== model_out()) begin
                errors++; $display("FAIL cal_hold cycle %0d: got %h expected %h", n, obs, model_out());
            end
        end
        checks++;
        if (tx_dig !== '1 || tx_ready !== 1'b0) begin
            errors++; $display("FAIL cal_hold_tx_held: got dig=%b rdy=%b expected dig=1111 rdy=0", tx_dig, tx_ready);
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++; $display("FAIL cal_hold_rx_independent: got rx_ready=%b expected 1", rx_ready);
        end
        tx_cal_busy = '0;
        for (int k = 1; k <= 30; k++) begin
            step();
            checks++;
            if (obs !== model_out()) begin
                errors++; $display("FAIL cal_release cycle %0d: got %h expected %h", k, obs, model_out());
            end
            if (t_rel < 0 && tx_dig == '0) t_rel = k;
        end
        checks++;
        if (t_rel != 2 + T_DRST) begin
            errors++; $display("FAIL cal_release_edge: got %0d expected %0d", t_rel, 2 + T_DRST);
        end
    endtask

    task automatic test_lock_glitch();
        int t_rel = -1;
        int guard = 0;
        set_good();
        apply_reset();
        while (rx_run != 150 && guard < 400) begin
            step();
            guard++;
            checks++;
            if (obs !== model_out()) begin
                errors++; $display("FAIL glitch_pre cycle %0d: got %h expected %h", guard, obs, model_out());
            end
        end
        checks++;
        if (guard >= 400) begin
            errors++; $display("FAIL glitch_reach_150: got timeout after %0d cycles expected count 150", guard);
        end
        rx_ltd[$urandom_range(0, CH_N - 1)] = 1'b0;
        step();
        rx_ltd = '1;
        for (int k = 1; k <= T_LTD + 20; k++) begin
            step();
            checks++;
            if (obs !== model_out()) begin
                errors++; $display("FAIL glitch_post cycle %0d: got %h expected %h", k, obs, model_out());
            end
            if (t_rel < 0 && rx_dig == '0) t_rel = k;
        end
        checks++;
        if (t_rel != T_LTD + 2) begin
            errors++; $display("FAIL glitch_release_edge: got %0d expected %0d", t_rel, T_LTD + 2);
        end
    endtask

    task automatic test_loss_in_service();
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++; $display("FAIL loss_precondition: got rx_ready=%b expected 1", rx_ready);
        end
        rx_ltd[$urandom_range(0, CH_N - 1)] = 1'b0;
        for (int k = 1; k <= 3; k++) step();
        checks++;
        if (rx_ready !== 1'b0 || rx_dig !== '1) begin
            errors++; $display("FAIL loss_within_3: got rdy=%b dig=%b expected rdy=0 dig=1111", rx_ready, rx_dig);
        end
        for (int k = 1; k <= 10; k++) step();
        rx_ltd = '1;
        for (int k = 1; k <= T_LTD + 5; k++) begin
            step();
            checks++;
            if (obs !== model_out()) begin
                errors++; $display("FAIL loss_recover cycle %0d: got %h expected %h", k, obs, model_out());
            end
        end
        checks++;
        if (rx_ready !== 1'b1 || tx_ready !== 1'b1) begin
            errors++; $display("FAIL loss_recovered: got rx=%b tx=%b expected 1 1", rx_ready, tx_ready);
        end
    endtask

    task automatic test_mid_reset();
        int t_tx = -1;
        set_good();
        apply_reset();
        for (int n = 1; n <= 2 + T_ARST + 2; n++) step();
        FPGA_RSTn = 1'b0;
        #1;
        checks++;
        if (obs !== RESET_VEC) begin
            errors++; $display("FAIL mid_reset_async: got %h expected %h", obs, RESET_VEC);
        end
        model_reset();
        repeat (3) @(negedge OSC_50m);
        FPGA_RSTn = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            step();
            checks++;
            if (obs !== model_out()) begin
                errors++; $display("FAIL mid_reset_restart cycle %0d: got %h expected %h", n, obs, model_out());
            end
            if (t_tx < 0 && tx_ready) t_tx = n;
        end
        checks++;
        if (t_tx != 2 + T_ARST + T_DRST) begin
            errors++; $display("FAIL mid_reset_tx_ready_edge: got %0d expected %0d", t_tx, 2 + T_ARST + T_DRST);
        end
    endtask

    task automatic test_random();
        int lvl = 0;
        set_good();
        apply_reset();
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) lvl = $urandom_range(0, 3);
            pll_locked = ($urandom_range(0, 999) >= lvl * 5);
            for (int l = 0; l < CH_N; l++) begin
                tx_cal_busy[l] = ($urandom_range(0, 999) < lvl * 2);
                rx_cal_busy[l] = ($urandom_range(0, 999) < lvl * 2);
`ifdef GX_RESET_LTD_WATCHDOG_EN
                rx_ltd[l] = 1'b1;
`else
                rx_ltd[l] = ($urandom_range(0, 999) >= lvl * 3);
`endif
            end
            step();
            checks++;
            if (obs !== model_out()) begin
                errors++; $display("FAIL random cycle %0d: got %h expected %h", n, obs, model_out());
            end
        end
    endtask

`ifdef GX_RESET_LTD_WATCHDOG_EN
    task automatic test_watchdog();
        int p1 = -1, p2 = -1;
        set_good();
        rx_ltd = '0;
        apply_reset();
        for (int n = 1; n <= 3000 && p2 < 0; n++) begin
            step();
            if (rx_wd_retry) begin
                checks++;
                if (rx_an !== '1) begin
                    errors++; $display("FAIL wd_analog_on_retry: got %b expected 1111", rx_an);
                end
                if (p1 < 0) p1 = n;
                else p2 = n;
                step();
                n++;
                checks++;
                if (rx_wd_retry !== 1'b0) begin
                    errors++; $display("FAIL wd_pulse_width: got %b expected 0", rx_wd_retry);
                end
            end
        end
        checks++;
        if (p1 != 2 + T_ARST + 1 + T_WD) begin
            errors++; $display("FAIL wd_first_retry: got %0d expected %0d", p1, 2 + T_ARST + 1 + T_WD);
        end
        checks++;
        if (p2 - p1 != T_WD + T_ARST + 1 || p2 < 0) begin
            errors++; $display("FAIL wd_interval: got %0d expected %0d", p2 - p1, T_WD + T_ARST + 1);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++; $display("FAIL wd_tx_independent: got %b expected 1", tx_ready);
        end
    endtask
`endif

    initial begin
        FPGA_RSTn = 1'b0;
        set_good();
        model_reset();
        test_reset();
        test_power_up();
        test_cal_hold();
        test_lock_glitch();
        test_loss_in_service();
        test_mid_reset();
        test_random();
`ifdef GX_RESET_LTD_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got no finish expected finish before 5 ms");
        $fatal(1, "timeout");
    end

endmodule
